// File: rtl/sd_cmd_pkg.sv
// Shared constants and FSM state type for the SD card-side CMD responder.
package sd_cmd_pkg;
  localparam int         FRAME_LEN   = 48;
  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam logic [5:0] IDX_GO_IDLE = 6'd0;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    WAIT,
    TX
  } state_t;
endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock, MSB-first data.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line: receives host command frames, answers with R1-style frames.
// Host CRC7 checking (and its RX CRC engine) exists only with SD_RESP_CRC_CHECK_EN.
//
//   state | meaning
//   IDLE  | line idle, waiting for a host start bit
//   RX    | shifting in the remaining 47 frame bits
//   CHECK | one cycle: qualify frame, publish index/argument
//   WAIT  | NCR turnaround down-count before the response
//   TX    | driving the 48-bit response, then the driver releases
module sd_card_cmd_responder
  import sd_cmd_pkg::*;
#(
  parameter int NCR = 2
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        cmd_pin_in,
  input  logic [31:0] card_status,
  output logic        cmd_pin_out,
  output logic        cmd_pin_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err
);

  state_t                 state;
  logic [FRAME_LEN-1:0]   sr;
  logic [5:0]             cnt;
  logic [6:0]             tx_crc;
  logic                   tx_clear;
  logic                   tx_en;
  logic                   tx_bit;
  logic                   launch;
  logic                   crc_ok;
  logic                   frame_ok;
  logic [2:0]             crc_sel;

`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       rx_clear;
  logic       rx_en;

  // The start bit is always 0, so clearing in IDLE already accounts for it.
  assign rx_clear = (state == IDLE);
  assign rx_en    = (state == RX) && (cnt >= 6'd8);
  assign crc_ok   = (sr[7:1] == rx_crc);

  sd_crc7 u_rx_crc (
    .clk_sys (sd_clock),
    .rst_b   (reset),
    .clear   (rx_clear),
    .enable  (rx_en),
    .bit_in  (cmd_pin_in),
    .crc     (rx_crc)
  );
`else
  assign crc_ok = 1'b1;
`endif

  assign frame_ok = sr[0] && crc_ok;
  assign launch   = (state == WAIT) && (cnt == 6'd0);
  assign tx_clear = (state != WAIT) && (state != TX);
  assign tx_en    = launch || ((state == TX) && (cnt >= 6'd9));
  assign tx_bit   = (state == TX) ? sr[FRAME_LEN-1] : 1'b0;
  // cnt 8..2 selects CRC bits 6..0 (wraps modulo 8)
  assign crc_sel  = cnt[2:0] - 3'd2;

  sd_crc7 u_tx_crc (
    .clk_sys (sd_clock),
    .rst_b   (reset),
    .clear   (tx_clear),
    .enable  (tx_en),
    .bit_in  (tx_bit),
    .crc     (tx_crc)
  );

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      cmd_pin_out <= 1'b1;
      cmd_pin_oe  <= 1'b0;
      cmd_valid   <= 1'b0;
      crc_err     <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
    end else begin
      cmd_valid <= 1'b0;
      crc_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!cmd_pin_in) begin
            sr    <= '0;
            cnt   <= 6'd46;
            state <= RX;
          end
        end
        RX: begin
          sr  <= {sr[FRAME_LEN-2:0], cmd_pin_in};
          cnt <= cnt - 6'd1;
          if ((cnt == 6'd46) && !cmd_pin_in) begin
            state <= IDLE;
          end else if (cnt == 6'd0) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (frame_ok) begin
            cmd_valid <= 1'b1;
            cmd_index <= sr[45:40];
            cmd_arg   <= sr[39:8];
            if (sr[45:40] == IDX_GO_IDLE) begin
              state <= IDLE;
            end else begin
              cnt   <= 6'(NCR - 1);
              state <= WAIT;
            end
          end else begin
            crc_err <= 1'b1;
            state   <= IDLE;
          end
        end
        WAIT: begin
          if (launch) begin
            cmd_pin_out <= 1'b0;
            cmd_pin_oe  <= 1'b1;
            sr          <= {1'b0, cmd_index, card_status, 9'h1FF};
            cnt         <= 6'd47;
            state       <= TX;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        TX: begin
          cnt <= cnt - 6'd1;
          if (cnt >= 6'd9) begin
            cmd_pin_out <= sr[FRAME_LEN-1];
            sr          <= {sr[FRAME_LEN-2:0], 1'b1};
          end else if (cnt >= 6'd2) begin
            cmd_pin_out <= tx_crc[crc_sel];
          end else if (cnt == 6'd1) begin
            cmd_pin_out <= 1'b1;
          end else begin
            cmd_pin_oe  <= 1'b0;
            cmd_pin_out <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Self-checking bench for sd_card_cmd_responder: directed frames plus randomized traffic.
module tb_sd_card_cmd_responder;

  localparam int NCR = 2;

  logic        sd_clock = 1'b0;
  logic        reset;
  logic        cmd_pin_in;
  logic [31:0] card_status;
  logic        cmd_pin_out;
  logic        cmd_pin_oe;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        crc_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [5:0]  m_index;
  logic [31:0] m_arg;

  sd_card_cmd_responder #(.NCR(NCR)) dut (
    .sd_clock    (sd_clock),
    .reset       (reset),
    .cmd_pin_in  (cmd_pin_in),
    .card_status (card_status),
    .cmd_pin_out (cmd_pin_out),
    .cmd_pin_oe  (cmd_pin_oe),
    .cmd_valid   (cmd_valid),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .crc_err     (crc_err)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC7 as polynomial long division of {data, 7'b0} by x^7 + x^3 + 1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic run_cmd(input logic [47:0] f, input logic [31:0] st, input int abort_bit);
    logic        good;
    logic        exp_resp;
    logic [47:0] exp_r;
    logic [47:0] resp;
    int          first_oe;
    int          n_hi;
    card_status = st;
    good = f[0] && f[46];
`ifdef SD_RESP_CRC_CHECK_EN
    good = good && (crc7_ref(f[47:8]) == f[7:1]);
`endif
    exp_resp = good && (f[45:40] != 6'd0);
    exp_r    = {2'b00, f[45:40], st, crc7_ref({2'b00, f[45:40], st}), 1'b1};
    resp     = '0;
    first_oe = -1;
    n_hi     = 0;
    for (int i = 47; i >= 0; i--) begin
      cmd_pin_in = f[i];
      @(negedge sd_clock);
    end
    cmd_pin_in = 1'b1;
    check_val("valid_early", cmd_valid, 1'b0);
    @(negedge sd_clock);
    check_val("cmd_valid", cmd_valid, good);
    check_val("crc_err", crc_err, !good);
    if (good) begin
      m_index = f[45:40];
      m_arg   = f[39:8];
    end
    check_val("cmd_index", cmd_index, m_index);
    check_val("cmd_arg", cmd_arg, m_arg);
    for (int c = 2; c <= NCR + 49; c++) begin
      @(negedge sd_clock);
      if (c == 2) begin
        check_val("valid_one_cycle", cmd_valid, 1'b0);
        check_val("err_one_cycle", crc_err, 1'b0);
      end
      if (abort_bit >= 0 && c == NCR + 1 + abort_bit) begin
        check_val("oe_before_rst", cmd_pin_oe, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_val("oe_in_rst", cmd_pin_oe, 1'b0);
        check_val("out_in_rst", cmd_pin_out, 1'b1);
        @(negedge sd_clock);
        reset   = 1'b1;
        m_index = '0;
        m_arg   = '0;
        check_val("idx_after_rst", cmd_index, m_index);
        check_val("arg_after_rst", cmd_arg, m_arg);
        return;
      end
      if (cmd_pin_oe) begin
        if (first_oe < 0) first_oe = c;
        resp = {resp[46:0], cmd_pin_out};
        n_hi++;
      end
      if (c == NCR + 1) card_status = $urandom;
    end
    check_val("oe_released", cmd_pin_oe, 1'b0);
    check_val("out_idle", cmd_pin_out, 1'b1);
    if (exp_resp) begin
      check_val("resp_start", first_oe, NCR + 1);
      check_val("resp_len", n_hi, 48);
      check_val("resp_frame", resp, exp_r);
    end else begin
      check_val("no_resp", n_hi, 0);
    end
  endtask

  task automatic send_bogus();
    int n_pulse;
    n_pulse = 0;
    cmd_pin_in = 1'b0;
    @(negedge sd_clock);
    @(negedge sd_clock);
    cmd_pin_in = 1'b1;
    for (int c = 0; c < 55; c++) begin
      @(negedge sd_clock);
      if (cmd_valid || crc_err || cmd_pin_oe) n_pulse++;
    end
    check_val("bogus_silent", n_pulse, 0);
    check_val("bogus_idx", cmd_index, m_index);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    logic [5:0]  idx;
    int          kind;
    reset       = 1'b0;
    cmd_pin_in  = 1'b1;
    card_status = '0;
    m_index     = '0;
    m_arg       = '0;
    repeat (3) @(negedge sd_clock);
    check_val("rst_out", cmd_pin_out, 1'b1);
    check_val("rst_oe", cmd_pin_oe, 1'b0);
    check_val("rst_valid", cmd_valid, 1'b0);
    check_val("rst_err", crc_err, 1'b0);
    check_val("rst_index", cmd_index, 6'd0);
    check_val("rst_arg", cmd_arg, 32'd0);
    reset = 1'b1;
    @(negedge sd_clock);

    check_val("cmd8_frame_ref", mk_frame(6'd8, 32'h0000_01AA), 48'h48_000001AA_87);
    run_cmd(48'h48_000001AA_87, $urandom, -1);
    run_cmd(48'h51_00000000_55, 32'h0000_0900, -1);
    run_cmd(48'h40_00000000_95, $urandom, -1);
    run_cmd(48'h51_00000000_57, $urandom, -1);
    send_bogus();
    run_cmd(48'h48_000001AA_87, $urandom, -1);
    run_cmd(48'h48_000001AA_87, $urandom, 20);
    run_cmd(48'h48_000001AA_87, $urandom, -1);

    for (int n = 0; n < 40; n++) begin
      idx  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      f    = mk_frame(idx, $urandom);
      kind = $urandom_range(0, 5);
      if (kind == 0) f[$urandom_range(1, 7)] = ~f[$urandom_range(1, 7)];
      if (kind == 1) f[0] = 1'b0;
      run_cmd(f, $urandom, -1);
      repeat ($urandom_range(0, 3)) @(negedge sd_clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
